top_chip_intr_ctrl: RTL and testbench



---
 rtl/top_chip_intr_ctrl.sv | 179 +++++++++++++++++
 tb/tb_top_chip_intr_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/top_chip_intr_ctrl.sv
// -----------------------------------------------------------------------------
// top_chip_intr_ctrl
//
// Interrupt controller for the Sunburst system. Each level interrupt line goes
// through its own gateway (IDLE -> PENDING -> CLAIMED -> IDLE). Pending sources
// that are enabled and whose priority is strictly above the threshold compete.
// The highest priority wins, and ties go to the lowest index. The winner is
// registered onto irq_o / irq_id_o, and the CPU releases it through a
// claim/complete handshake.
//
// Source vector layout: {uart, spi_host, i2c, aon_timer}. aon_timer is bits 1:0.
//
// Optional build macro: TOP_CHIP_INTR_CTRL_SRC_SYNC_EN
//   defined   : each intr_src_i bit passes through a 2-flop synchronizer
//               (+2 cycles source-to-gateway latency).
//   undefined : intr_src_i is sampled directly and must already be synchronous
//               to clk_i.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   intr_src_i     level interrupt lines, bit i = source i
//   cfg_we_i       config write strobe (indexes >= NumSrc are ignored)
//   cfg_idx_i      source index for the config write
//   cfg_en_i       enable value to write
//   cfg_prio_i     priority value to write
//   threshold_i    global threshold; a source must have prio > threshold
//   irq_o          registered interrupt request to the CPU
//   irq_id_o       registered winning source index; holds its value while irq_o=0
//   claim_i        CPU claims the source shown on irq_id_o (only when irq_o=1)
//   complete_i     CPU signals that the handler is done
//   complete_id_i  source being completed (only acts on a CLAIMED source)
// -----------------------------------------------------------------------------
module top_chip_intr_ctrl #(
  parameter int NumSrc    = 28,
  parameter int PrioWidth = 2,
  parameter int IdWidth   = $clog2(NumSrc)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumSrc-1:0]    intr_src_i,
  input  logic                 cfg_we_i,
  input  logic [IdWidth-1:0]   cfg_idx_i,
  input  logic                 cfg_en_i,
  input  logic [PrioWidth-1:0] cfg_prio_i,
  input  logic [PrioWidth-1:0] threshold_i,
  output logic                 irq_o,
  output logic [IdWidth-1:0]   irq_id_o,
  input  logic                 claim_i,
  input  logic                 complete_i,
  input  logic [IdWidth-1:0]   complete_id_i
);

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  // Source lines as seen by the gateways.
  logic [NumSrc-1:0] src_gw;

`ifdef TOP_CHIP_INTR_CTRL_SRC_SYNC_EN
  logic [NumSrc-1:0] src_meta_reg;
  logic [NumSrc-1:0] src_sync_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_meta_reg <= '0;
      src_sync_reg <= '0;
    end else begin
      src_meta_reg <= intr_src_i;
      src_sync_reg <= src_meta_reg;
    end
  end

  assign src_gw = src_sync_reg;
`else
  assign src_gw = intr_src_i;
`endif

  logic                        irq_reg;
  logic [IdWidth-1:0]          irq_id_reg;
  logic [NumSrc-1:0]           elig;
  logic [NumSrc*PrioWidth-1:0] prio_vec;

  // ---------------------------------------------------------------------------
  // Per-source configuration registers and gateway FSM
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NumSrc; gi++) begin : g_src
      logic                 en_reg;
      logic [PrioWidth-1:0] prio_reg;
      gw_state_e            state_reg;
      gw_state_e            state_next;
      logic                 cfg_hit;
      logic                 claim_hit;
      logic                 complete_hit;

      // An out-of-range cfg_idx_i or complete_id_i never matches any gi.
      assign cfg_hit      = cfg_we_i && (cfg_idx_i == IdWidth'(gi));
      // A claim acts on the registered outputs, so a source disabled in the
      // same cycle can still be claimed.
      assign claim_hit    = claim_i && irq_reg && (irq_id_reg == IdWidth'(gi));
      assign complete_hit = complete_i && (complete_id_i == IdWidth'(gi));

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          en_reg    <= 1'b0;
          prio_reg  <= '0;
          state_reg <= GW_IDLE;
        end else begin
          if (cfg_hit) begin
            en_reg   <= cfg_en_i;
            prio_reg <= cfg_prio_i;
          end
          state_reg <= state_next;
        end
      end

      // The line is only looked at in IDLE. While PENDING it is already latched,
      // and while CLAIMED it is masked until the CPU completes.
      always_comb begin
        state_next = state_reg;
        case (state_reg)
          GW_IDLE:    if (src_gw[gi])  state_next = GW_PENDING;
          GW_PENDING: if (claim_hit)   state_next = GW_CLAIMED;
          GW_CLAIMED: if (complete_hit) state_next = GW_IDLE;
          default:    state_next = GW_IDLE;
        endcase
      end

      // Mask the source being claimed this cycle. The output register updated
      // on the claim edge then already shows the next winner rather than the
      // source that was just taken.
      assign elig[gi] = (state_reg == GW_PENDING) && en_reg &&
                        (prio_reg > threshold_i) && !claim_hit;
      assign prio_vec[gi*PrioWidth +: PrioWidth] = prio_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration: highest priority wins. Strict '>' in an ascending scan keeps
  // the lowest index on ties.
  // ---------------------------------------------------------------------------
  logic                 arb_any;
  logic [IdWidth-1:0]   arb_id;
  logic [PrioWidth-1:0] arb_prio;

  always_comb begin
    arb_any  = 1'b0;
    arb_id   = '0;
    arb_prio = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (elig[i] && (!arb_any || (prio_vec[i*PrioWidth +: PrioWidth] > arb_prio))) begin
        arb_any  = 1'b1;
        arb_id   = IdWidth'(i);
        arb_prio = prio_vec[i*PrioWidth +: PrioWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_reg    <= 1'b0;
      irq_id_reg <= '0;
    end else begin
      irq_reg <= arb_any;
      if (arb_any) begin
        irq_id_reg <= arb_id;
      end
    end
  end

  assign irq_o    = irq_reg;
  assign irq_id_o = irq_id_reg;

endmodule

// File: tb/tb_top_chip_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_top_chip_intr_ctrl
//
// Directed testbench for top_chip_intr_ctrl. The expected values are worked out
// by hand from the controller behaviour. Outputs are sampled 1 time unit after
// the rising clock edge.
// -----------------------------------------------------------------------------
module tb_top_chip_intr_ctrl;

`ifdef TOP_CHIP_INTR_CTRL_SRC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [27:0] intr_src_i;
  logic        cfg_we_i;
  logic [4:0]  cfg_idx_i;
  logic        cfg_en_i;
  logic [1:0]  cfg_prio_i;
  logic [1:0]  threshold_i;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        claim_i;
  logic        complete_i;
  logic [4:0]  complete_id_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  top_chip_intr_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .intr_src_i    (intr_src_i),
    .cfg_we_i      (cfg_we_i),
    .cfg_idx_i     (cfg_idx_i),
    .cfg_en_i      (cfg_en_i),
    .cfg_prio_i    (cfg_prio_i),
    .threshold_i   (threshold_i),
    .irq_o         (irq_o),
    .irq_id_o      (irq_id_o),
    .claim_i       (claim_i),
    .complete_i    (complete_i),
    .complete_id_i (complete_id_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s = %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic cfg(input int idx, input logic en, input int prio);
    cfg_we_i   = 1'b1;
    cfg_idx_i  = idx[4:0];
    cfg_en_i   = en;
    cfg_prio_i = prio[1:0];
    tick(1);
    cfg_we_i   = 1'b0;
  endtask

  task automatic claim();
    claim_i = 1'b1;
    tick(1);
    claim_i = 1'b0;
  endtask

  task automatic complete(input int id);
    complete_i    = 1'b1;
    complete_id_i = id[4:0];
    tick(1);
    complete_i    = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    intr_src_i    = '1;
    cfg_we_i      = 1'b0;
    cfg_idx_i     = '0;
    cfg_en_i      = 1'b0;
    cfg_prio_i    = '0;
    threshold_i   = '0;
    claim_i       = 1'b0;
    complete_i    = 1'b0;
    complete_id_i = '0;

    // 1. Reset with all lines high, then nothing enabled.
    tick(2);
    check("rst_irq", irq_o, 0);
    check("rst_id", irq_id_o, 0);
    rst_i = 1'b0;
    tick(3 + SYNC_LAT);
    check("no_en_irq", irq_o, 0);
    cfg(5, 1'b1, 1);
    check("cfg_lat_irq", irq_o, 0);
    tick(1);
    check("cfg5_irq", irq_o, 1);
    check("cfg5_id", irq_id_o, 5);

    // 2. Priority and threshold handling.
    cfg(5, 1'b0, 1);
    cfg(3, 1'b1, 2);
    cfg(9, 1'b1, 3);
    threshold_i = 2'd1;
    tick(1);
    check("prio_irq", irq_o, 1);
    check("prio_id", irq_id_o, 9);
    claim();
    check("claim9_irq", irq_o, 1);
    check("claim9_next_id", irq_id_o, 3);
    threshold_i = 2'd2;
    tick(1);
    check("thr_eq_irq", irq_o, 0);
    check("thr_hold_id", irq_id_o, 3);
    threshold_i = 2'd1;
    tick(1);
    check("thr_back_irq", irq_o, 1);
    check("thr_back_id", irq_id_o, 3);
    claim();
    check("claim3_irq", irq_o, 0);

    // 3. Tie-break on equal priority, and an out-of-range config write.
    cfg(20, 1'b1, 2);
    cfg(7, 1'b1, 2);
    tick(1);
    check("tie_irq", irq_o, 1);
    check("tie_id", irq_id_o, 7);
    cfg(30, 1'b1, 3);
    tick(1);
    check("bad_idx_id", irq_id_o, 7);

    // 4. Claim/complete handshake with the line held high.
    claim();
    check("claim7_id", irq_id_o, 20);
    tick(2);
    check("no_repend_id", irq_id_o, 20);
    complete(8);
    tick(2);
    check("cmp_wrong_id", irq_id_o, 20);
    complete(7);
    check("cmp_edge_id", irq_id_o, 20);
    tick(2);
    check("cmp_repend_irq", irq_o, 1);
    check("cmp_repend_id", irq_id_o, 7);

    // 5. Same-cycle claim and complete, then reset mid-operation.
    complete(9);
    tick(2);
    check("repend9_id", irq_id_o, 9);
    claim_i       = 1'b1;
    complete_i    = 1'b1;
    complete_id_i = 5'd3;
    tick(1);
    claim_i    = 1'b0;
    complete_i = 1'b0;
    check("dual_id", irq_id_o, 7);
    tick(2);
    check("repend3_id", irq_id_o, 3);
    rst_i = 1'b1;
    tick(1);
    check("midrst_irq", irq_o, 0);
    check("midrst_id", irq_id_o, 0);
    rst_i = 1'b0;
    tick(3 + SYNC_LAT);
    check("post_rst_irq", irq_o, 0);
    threshold_i = 2'd0;
    cfg(3, 1'b1, 1);
    tick(1);
    check("post_rst_en_irq", irq_o, 1);
    check("post_rst_en_id", irq_id_o, 3);

    // 6. One-cycle pulse on source 0: latched, and irq latency depends on the build.
    intr_src_i = '0;
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
    cfg(0, 1'b1, 3);
    tick(2);
    check("pulse_pre_irq", irq_o, 0);
    intr_src_i = 28'd1;
    tick(1);
    intr_src_i = '0;
    check("pulse_edge_irq", irq_o, 0);
    for (int k = 1; k <= 1 + SYNC_LAT; k++) begin
      tick(1);
      check($sformatf("pulse_lat%0d_irq", k), irq_o, (k == 1 + SYNC_LAT) ? 1 : 0);
    end
    tick(2);
    check("pulse_latched_irq", irq_o, 1);
    check("pulse_latched_id", irq_id_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
